// File: rtl/window_pkg.sv
// Shared types and defaults for the 2x2 window controller.
package window_pkg;

  localparam int COORD_W           = 11;
  localparam int DEF_FRAME_H_PIXEL = 1920;
  localparam int DEF_FRAME_V_PIXEL = 1080;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FIRST_LINE = 2'd1,
    ACTIVE     = 2'd2,
    DONE       = 2'd3
  } win_state_t;

endpackage

// File: rtl/window_2x2_ctrl_if.sv
// Frame-in / window-out bundle of the 2x2 window controller.
// err_line_len exists only when WIN_ERR_CHECK_EN is defined.
interface window_2x2_ctrl_if;
  import window_pkg::*;

  logic   frame_i_vs;
  logic   frame_i_hs;
  logic   frame_i_valid;
  logic   frame_rst;
  logic   win_valid;
  coord_t win_x;
  coord_t win_y;
  logic   frame_done;

`ifdef WIN_ERR_CHECK_EN
  logic   err_line_len;

  modport master (
    output frame_i_vs, frame_i_hs, frame_i_valid,
    input  frame_rst, win_valid, win_x, win_y, frame_done, err_line_len
  );

  modport slave (
    input  frame_i_vs, frame_i_hs, frame_i_valid,
    output frame_rst, win_valid, win_x, win_y, frame_done, err_line_len
  );
`else
  modport master (
    output frame_i_vs, frame_i_hs, frame_i_valid,
    input  frame_rst, win_valid, win_x, win_y, frame_done
  );

  modport slave (
    input  frame_i_vs, frame_i_hs, frame_i_valid,
    output frame_rst, win_valid, win_x, win_y, frame_done
  );
`endif

endinterface

// File: rtl/sync_edge_det.sv
// Registered rise/fall detector. The first sample after reset only
// primes the history, so a level already high at release is no edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;
  logic armed;

  // One-cycle history of d plus a flag marking the history as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed &  d & ~d_q;
  assign fall = armed & ~d &  d_q;

endmodule

// File: rtl/window_2x2_ctrl.sv
// 2x2 window controller: tracks pixel position within a frame and tells
// the line-buffer datapath when a complete 2x2 window is available.
// Optional macro WIN_ERR_CHECK_EN adds the sticky err_line_len flag.
//
// state      | meaning
// IDLE       | waiting for a vs rising edge, pixels ignored
// FIRST_LINE | filling line 0, no window possible yet
// ACTIVE     | lines 1.., window on every pixel with x >= 1
// DONE       | one cycle after the last pixel, frame_done high
module window_2x2_ctrl
  import window_pkg::*;
#(
  parameter int FRAME_H_PIXEL = DEF_FRAME_H_PIXEL,
  parameter int FRAME_V_PIXEL = DEF_FRAME_V_PIXEL
) (
  input  logic             clk,
  input  logic             rst,
  window_2x2_ctrl_if.slave bus
);

  localparam coord_t H_LAST = coord_t'(FRAME_H_PIXEL - 1);
  localparam coord_t V_LAST = coord_t'(FRAME_V_PIXEL - 1);

  win_state_t state;
  coord_t     pix_x, pix_y;
  coord_t     win_x_q, win_y_q;
  logic       frame_rst_q, win_valid_q, frame_done_q;
  logic       vs_rise, vs_fall, hs_rise, hs_fall;
  logic       in_line;
  logic       take;

  sync_edge_det u_vs_det (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.frame_i_vs),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_det u_hs_det (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.frame_i_hs),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  assign in_line = (state == FIRST_LINE) || (state == ACTIVE);
  // A pixel coinciding with a new vs edge or with frame_rst is dropped.
  assign take    = bus.frame_i_valid && in_line && !vs_rise && !frame_rst_q;

  // Frame FSM, pixel counters and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pix_x        <= '0;
      pix_y        <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_rst_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_rst_q  <= vs_rise;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;

      if (vs_rise) begin
        state <= FIRST_LINE;
      end else begin
        unique case (state)
          IDLE:       state <= IDLE;
          FIRST_LINE: if (take && pix_x == H_LAST) state <= ACTIVE;
          ACTIVE: begin
            if (take && pix_x == H_LAST && pix_y == V_LAST) begin
              state        <= DONE;
              frame_done_q <= 1'b1;
            end
          end
          DONE:       state <= IDLE;
          default:    state <= IDLE;
        endcase
      end

      if (take && state == ACTIVE && pix_x != '0) begin
        win_valid_q <= 1'b1;
        win_x_q     <= pix_x;
        win_y_q     <= pix_y;
      end

      if (frame_rst_q) begin
        pix_x <= '0;
        pix_y <= '0;
      end else if (take) begin
        if (pix_x == H_LAST) begin
          pix_x <= '0;
          pix_y <= (pix_y == V_LAST) ? '0 : pix_y + coord_t'(1);
        end else begin
          pix_x <= pix_x + coord_t'(1);
        end
      end
    end
  end

  assign bus.frame_rst  = frame_rst_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.frame_done = frame_done_q;

  logic unused_edges;

`ifdef WIN_ERR_CHECK_EN
  logic err_q;

  // Sticky flag: an hs fall inside a frame must land on column 0.
  always_ff @(posedge clk) begin
    if (rst || frame_rst_q)                     err_q <= 1'b0;
    else if (hs_fall && in_line && pix_x != '0) err_q <= 1'b1;
  end

  assign bus.err_line_len = err_q;
  assign unused_edges     = ^{vs_fall, hs_rise};
`else
  assign unused_edges     = ^{vs_fall, hs_rise, hs_fall};
`endif

endmodule

// File: tb/tb_window_2x2_ctrl.sv
module tb_window_2x2_ctrl;
  import window_pkg::*;

  localparam int H = 4;
  localparam int V = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  window_2x2_ctrl_if bus ();

  window_2x2_ctrl #(.FRAME_H_PIXEL(H), .FRAME_V_PIXEL(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a linear run of pixel indices 0..H*V-1.
  bit          m_vs_q, m_hs_q, m_primed, m_in_frame;
  int          m_idx;
  logic        e_frst, e_wv, e_done, e_err;
  logic [10:0] e_wx, e_wy;

  function automatic logic [25:0] obs();
`ifdef WIN_ERR_CHECK_EN
    return {bus.frame_rst, bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.err_line_len};
`else
    return {bus.frame_rst, bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, 1'b0};
`endif
  endfunction

  function automatic logic [25:0] expv();
    return {e_frst, e_wv, e_wx, e_wy, e_done, e_err};
  endfunction

  // Apply one cycle of inputs, advance the model, wait past the edge.
  task automatic step(input logic r, input logic vs, input logic hs, input logic v);
    bit rise, hfall;
    rst = r; bus.frame_i_vs = vs; bus.frame_i_hs = hs; bus.frame_i_valid = v;
    if (r) begin
      m_vs_q = 0; m_hs_q = 0; m_primed = 0; m_in_frame = 0; m_idx = 0;
      e_frst = 0; e_wv = 0; e_done = 0; e_err = 0; e_wx = '0; e_wy = '0;
    end else begin
      rise  = m_primed && vs && !m_vs_q;
      hfall = m_primed && !hs && m_hs_q;
`ifdef WIN_ERR_CHECK_EN
      if (e_frst) e_err = 0;
      else if (hfall && m_in_frame && (m_idx % H) != 0) e_err = 1;
`endif
      e_wv = 0; e_done = 0;
      if (rise) m_in_frame = 1;
      else if (e_frst) m_idx = 0;
      else if (m_in_frame && v) begin
        if (m_idx / H >= 1 && m_idx % H >= 1) begin
          e_wv = 1; e_wx = 11'(m_idx % H); e_wy = 11'(m_idx / H);
        end
        if (m_idx == H * V - 1) begin
          e_done = 1; m_in_frame = 0;
        end
        m_idx = (m_idx + 1) % (H * V);
      end
      e_frst = rise;
      m_vs_q = vs; m_hs_q = hs; m_primed = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    n_checks++;
    if (obs() !== 26'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs());
    end
    n_checks++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_checks++;
    if (obs() !== expv() || bus.win_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid_ignored: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_full_frame();
    logic [21:0] got[$];
    logic [21:0] want[$];
    int dones = 0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    n_checks++;
    if (bus.frame_rst !== 1'b1) begin
      n_fail++; $display("FAIL frame_rst_latency: got %b want 1", bus.frame_rst);
    end
    for (int i = 0; i < 4 + H * V; i++) begin
      step(0, 0, 0, (i >= 1 && i <= H * V) ? 1'b1 : 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL full_frame cyc %0d: got %h want %h", i, obs(), expv());
      end
      if (bus.win_valid === 1'b1) got.push_back({bus.win_x, bus.win_y});
      if (bus.frame_done === 1'b1) dones++;
    end
    for (int y = 1; y < V; y++)
      for (int x = 1; x < H; x++) want.push_back({11'(x), 11'(y)});
    n_checks++;
    if (got != want) begin
      n_fail++; $display("FAIL full_frame_windows: got %0d windows want %0d", got.size(), want.size());
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL full_frame_done: got %0d pulses want 1", dones);
    end
  endtask

  task automatic test_valid_gaps();
    int wins = 0, dones = 0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3 * H * V + 6; i++) begin
      step(0, 0, 0, (i % 3 == 1) ? 1'b1 : 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL valid_gaps cyc %0d: got %h want %h", i, obs(), expv());
      end
      if (bus.win_valid === 1'b1) wins++;
      if (bus.frame_done === 1'b1) dones++;
    end
    n_checks++;
    if (wins != (H - 1) * (V - 1) || dones != 1) begin
      n_fail++; $display("FAIL valid_gaps_counts: got %0d/%0d want %0d/1", wins, dones, (H - 1) * (V - 1));
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 8 + 3 + H * V + 4; i++) begin
      if (i == 8) step(0, 1, 0, 0);
      else step(0, 0, 0, ((i >= 1 && i <= 6) || (i >= 11 && i < 11 + H * V)) ? 1'b1 : 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL abort cyc %0d: got %h want %h", i, obs(), expv());
      end
      if (bus.frame_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL abort_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_rst_coincide();
    bit seen = 0;
    logic [21:0] first_win = '0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < H * V + 5; i++) begin
      step(0, 0, 0, (i <= H * V) ? 1'b1 : 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL rst_coincide cyc %0d: got %h want %h", i, obs(), expv());
      end
      if (bus.win_valid === 1'b1 && !seen) begin
        seen = 1; first_win = {bus.win_x, bus.win_y};
      end
    end
    n_checks++;
    if (first_win !== {11'd1, 11'd1}) begin
      n_fail++; $display("FAIL rst_coincide_first_win: got %h want %h", first_win, {11'd1, 11'd1});
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0, frsts = 0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    n_checks++;
    if (obs() !== 26'd0 || dut.state !== IDLE) begin
      n_fail++; $display("FAIL mid_reset: got %h state %0d want 0 state %0d", obs(), dut.state, IDLE);
    end
    for (int i = 0; i < 5 + 1 + H * V + 4; i++) begin
      step(0, (i < 5 || i == 6) ? 1'b1 : 1'b0, 0, (i >= 8 && i < 8 + H * V) ? 1'b1 : 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL after_reset cyc %0d: got %h want %h", i, obs(), expv());
      end
      if (i < 6 && bus.frame_rst === 1'b1) frsts++;
      if (bus.frame_done === 1'b1) dones++;
    end
    n_checks++;
    if (frsts != 0 || dones != 1) begin
      n_fail++; $display("FAIL held_vs: got frame_rst %0d done %0d want 0 and 1", frsts, dones);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      bit done_seen = 0;
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 200 && !done_seen; i++) begin
        step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL random f%0d cyc %0d: got %h want %h", f, i, obs(), expv());
        end
        if (bus.frame_done === 1'b1) done_seen = 1;
      end
      n_checks++;
      if (!done_seen) begin
        n_fail++; $display("FAIL random_timeout f%0d: got no frame_done want 1", f);
      end
    end
  endtask

`ifdef WIN_ERR_CHECK_EN
  task automatic test_err_line_len();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < H; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.err_line_len !== 1'b0) begin
      n_fail++; $display("FAIL err_good_line: got %b want 0", bus.err_line_len);
    end
    step(0, 0, 1, 0);
    for (int i = 0; i < H - 1; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.err_line_len !== 1'b1) begin
      n_fail++; $display("FAIL err_short_line: got %b want 1", bus.err_line_len);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    n_checks++;
    if (bus.err_line_len !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL err_sticky: got %h want %h", obs(), expv());
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.err_line_len !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", bus.err_line_len);
    end
  endtask
`endif

  initial begin
    bus.frame_i_vs = 0; bus.frame_i_hs = 0; bus.frame_i_valid = 0;
    test_reset();
    test_full_frame();
    test_valid_gaps();
    test_abort();
    test_rst_coincide();
    test_mid_reset();
    test_random_frames();
`ifdef WIN_ERR_CHECK_EN
    test_err_line_len();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
